// File: rtl/handshake_sender.sv
// handshake_sender: buffers producer words in a small FIFO and transmits each one
// to a peripheral over a four-phase send/ack handshake, with an ack timeout so a
// dead peripheral cannot stall the producer forever.
module handshake_sender #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              send,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [15:0]       sent_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [TMR_W-1:0]  r_timer;
  logic              r_send;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [15:0]       r_sent;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_timeout;

  // FIFO status and handshake decode; a full FIFO refuses writes even when popping
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = wr_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_timeout = (r_state == S_REQ) && !ack_in && (r_timer == TMR_W'(TIMEOUT - 1));

  assign wr_ready    = !w_full;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign send        = r_send;
  assign data_out    = r_data;
  assign timeout_err = r_err;
  assign sent_count  = r_sent;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Handshake FSM with registered send/data_out, timeout timer and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_sent  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_data  <= r_mem[r_rd_ptr];
            r_send  <= 1'b1;
            r_timer <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_in) begin
            r_send  <= 1'b0;
            r_sent  <= r_sent + 16'd1;
            r_state <= S_RELEASE;
          end else if (w_timeout) begin
            r_send  <= 1'b0;
            r_state <= S_RELEASE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_RELEASE: begin
          // wait for the peripheral to drop ack before the next request
          if (!ack_in) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_send  <= 1'b0;
        end
      endcase

      // a timeout in the same cycle as a clear leaves the flag set
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender; inputs change and outputs are sampled on negedge.
module tb_handshake_sender;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        send;
  logic [15:0] data_out;
  logic        ack_in;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;
  logic [15:0] sent_count;

  int   n_cmp;
  int   n_err;
  logic auto_ack;

  handshake_sender #(
    .DATA_W (16),
    .DEPTH  (4),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .send       (send),
    .data_out   (data_out),
    .ack_in     (ack_in),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr),
    .sent_count (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; optional peripheral model returns send delayed by one register
  task automatic tick();
    logic s;
    s = send;
    @(negedge clk);
    if (auto_ack) ack_in = s;
  endtask

  initial begin
    int          hi;
    int          first_idle;
    int          nw;
    int          bad;
    logic        prev;
    logic [15:0] held;
    logic [15:0] words [5];

    n_cmp = 0;
    n_err = 0;
    auto_ack = 1'b0;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = 16'h0;
    ack_in = 1'b0;
    err_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check_eq("rst_send", 32'(send), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_cnt", 32'(sent_count), 32'd0);
    check_eq("rst_err", 32'(timeout_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);

    // single word with a one-cycle-latency peripheral
    auto_ack = 1'b1;
    wr_valid = 1'b1;
    wr_data = 16'hA5A5;
    tick();
    wr_valid = 1'b0;
    check_eq("single_busy0", 32'(busy), 32'd1);
    hi = 0;
    first_idle = 0;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (send) begin
        hi++;
        if (data_out != 16'hA5A5) bad++;
      end
      if (!busy && first_idle == 0) first_idle = k;
    end
    check_eq("single_send_hi", 32'(hi), 32'd2);
    check_eq("single_data_bad", 32'(bad), 32'd0);
    check_eq("single_idle_at", 32'(first_idle), 32'd5);
    check_eq("single_cnt", 32'(sent_count), 32'd1);

    // burst fill with stalled ack: 4 buffered + 1 in flight, 6th refused
    auto_ack = 1'b0;
    ack_in = 1'b0;
    wr_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = 16'(i);
      tick();
      if (i == 4) check_eq("burst_ready_4", 32'(wr_ready), 32'd1);
    end
    check_eq("burst_ready_5", 32'(wr_ready), 32'd0);
    wr_data = 16'h0006;
    tick();
    check_eq("burst_ready_6", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    auto_ack = 1'b1;
    nw = 0;
    bad = 0;
    prev = 1'b0;
    held = 16'h0;
    for (int k = 0; k < 40; k++) begin
      if (send && !prev) begin
        if (nw < 5) words[nw] = data_out;
        nw++;
        held = data_out;
      end else if (send && data_out != held) begin
        bad++;
      end
      prev = send;
      tick();
    end
    check_eq("burst_nwords", 32'(nw), 32'd5);
    for (int i = 0; i < 5; i++) check_eq("burst_order", 32'(words[i]), 32'(i + 1));
    check_eq("burst_stable", 32'(bad), 32'd0);
    check_eq("burst_cnt", 32'(sent_count), 32'd6);
    check_eq("burst_busy", 32'(busy), 32'd0);

    // ack timeout: word abandoned after exactly 8 request cycles
    auto_ack = 1'b0;
    ack_in = 1'b0;
    wr_valid = 1'b1;
    wr_data = 16'h1234;
    tick();
    wr_data = 16'h5678;
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) wr_valid = 1'b0;
      if (send) hi++;
      if (k == 8) begin
        check_eq("to_err_before", 32'(timeout_err), 32'd0);
        err_clr = 1'b1;
      end
      if (k == 9) begin
        check_eq("to_set_wins", 32'(timeout_err), 32'd1);
        err_clr = 1'b0;
      end
    end
    check_eq("to_send_hi", 32'(hi), 32'd8);
    check_eq("to_cnt", 32'(sent_count), 32'd6);
    tick();
    check_eq("to_next_send", 32'(send), 32'd1);
    check_eq("to_next_data", 32'(data_out), 32'h5678);
    auto_ack = 1'b1;
    repeat (6) tick();
    check_eq("to_next_cnt", 32'(sent_count), 32'd7);
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("to_err_clr", 32'(timeout_err), 32'd0);

    // slow release: ack held high for 10 cycles after send falls
    auto_ack = 1'b0;
    ack_in = 1'b0;
    wr_valid = 1'b1;
    wr_data = 16'hBEEF;
    tick();
    wr_data = 16'hCAFE;
    tick();
    wr_valid = 1'b0;
    check_eq("slow_send_up", 32'(send), 32'd1);
    check_eq("slow_data", 32'(data_out), 32'hBEEF);
    ack_in = 1'b1;
    tick();
    check_eq("slow_send_dn", 32'(send), 32'd0);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (send) hi++;
    end
    check_eq("slow_hold", 32'(hi), 32'd0);
    check_eq("slow_busy", 32'(busy), 32'd1);
    ack_in = 1'b0;
    tick();
    check_eq("slow_rise_1", 32'(send), 32'd0);
    tick();
    check_eq("slow_rise_2", 32'(send), 32'd1);
    check_eq("slow_data2", 32'(data_out), 32'hCAFE);
    auto_ack = 1'b1;
    repeat (8) tick();
    check_eq("slow_cnt", 32'(sent_count), 32'd9);

    // reset in REQ with three words queued
    auto_ack = 1'b0;
    ack_in = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'(16'h0100 + i);
      tick();
    end
    wr_valid = 1'b0;
    check_eq("mid_send_up", 32'(send), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_send", 32'(send), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_ready", 32'(wr_ready), 32'd1);
    check_eq("mid_cnt", 32'(sent_count), 32'd0);
    check_eq("mid_data", 32'(data_out), 32'd0);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (send || busy) hi++;
    end
    check_eq("mid_quiet", 32'(hi), 32'd0);

    // stale ack while idle and empty
    ack_in = 1'b1;
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (send || busy) hi++;
    end
    check_eq("stale_quiet", 32'(hi), 32'd0);
    check_eq("stale_cnt", 32'(sent_count), 32'd0);
    ack_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
